i2s_audio_receiver: RTL and testbench

- Recovers 2-channel PCM samples from an external I2S bus: bit clock, word select and serial data.
- All three I2S lines are oversampled in the single system clock domain.
- Output is a valid/ready sample stream tagged left/right: one word per channel slot.
- Sits directly upstream of the S/PDIF audio encoder and drives its i_valid/i_ready/i_audio/i_is_left inputs on the same clock.

---
 rtl/i2s_audio_receiver.sv | 173 +++++++++++++++++
 tb/tb_i2s_audio_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_receiver.sv
// I2S receiver: oversamples an external I2S bus in the clk domain and
// turns each left/right slot into one MSB-aligned word. Words go out on a
// valid/ready stream through a 2-entry FIFO. Slots longer than the word are
// truncated and shorter slots are zero-padded in the LSBs. Nothing is
// emitted until the first slot boundary has been seen after reset.
module i2s_audio_receiver #(
    parameter int audio_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i2s_bck,
    input  logic                   i2s_lrck,
    input  logic                   i2s_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [audio_width-1:0] o_audio,
    output logic                   o_is_left,
    output logic                   o_overrun
);

    localparam int cnt_w = $clog2(audio_width + 1);
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(audio_width);

    // Synchronizer and edge-detect flops
    logic bck_s1, bck_s2, bck_hist;
    logic lrck_s1, lrck_s2;
    logic data_s1, data_s2;
    logic bck_rise;

    // Registered bit strobe with the lrck/data values that belong to it
    logic bit_strobe;
    logic bit_lrck;
    logic bit_data;

    // Slot assembly state
    logic [audio_width-1:0] sh;
    logic [audio_width-1:0] sh_with_bit;
    logic [cnt_w-1:0]       cnt;
    logic [cnt_w-1:0]       cnt_inc;
    logic                   prev_lrck;
    logic                   locked;

    // Completed word waiting to enter the FIFO
    logic                   push_req;
    logic [audio_width-1:0] push_word;
    logic                   push_left;

    // Output FIFO
    logic [audio_width-1:0] fifo_audio [2];
    logic                   fifo_left  [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   full;
    logic                   pop;
    logic                   push_ok;

    // Bring the three asynchronous I2S lines into clk with 2-flop synchronizers
    always_ff @(posedge clk) begin
        if (reset) begin
            bck_s1   <= 1'b0;
            bck_s2   <= 1'b0;
            bck_hist <= 1'b0;
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            data_s1  <= 1'b0;
            data_s2  <= 1'b0;
        end else begin
            bck_s1   <= i2s_bck;
            bck_s2   <= bck_s1;
            bck_hist <= bck_s2;
            lrck_s1  <= i2s_lrck;
            lrck_s2  <= lrck_s1;
            data_s1  <= i2s_data;
            data_s2  <= data_s1;
        end
    end

    assign bck_rise = bck_s2 & ~bck_hist;

    // Capture lrck/data on each bit-clock rising edge so the decoder sees a clean strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_strobe <= 1'b0;
            bit_lrck   <= 1'b0;
            bit_data   <= 1'b0;
        end else begin
            bit_strobe <= bck_rise;
            bit_lrck   <= lrck_s2;
            bit_data   <= data_s2;
        end
    end

    // Insert the current bit at the next MSB-first position unless the word is already full
    always_comb begin
        sh_with_bit = sh;
        cnt_inc     = cnt;
        if (cnt < cnt_max) begin
            cnt_inc = cnt + 1'b1;
            for (int i = 0; i < audio_width; i++) begin
                if (cnt == cnt_w'(audio_width - 1 - i)) begin
                    sh_with_bit[i] = bit_data;
                end
            end
        end
    end

    // Assemble slots; an lrck change marks the last bit of the previous slot
    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= '0;
            cnt       <= '0;
            prev_lrck <= 1'b0;
            locked    <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
            push_left <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (bit_strobe) begin
                if (bit_lrck == prev_lrck) begin
                    sh  <= sh_with_bit;
                    cnt <= cnt_inc;
                end else begin
                    push_req  <= locked;
                    push_word <= sh_with_bit;
                    push_left <= ~prev_lrck;
                    sh        <= '0;
                    cnt       <= '0;
                    prev_lrck <= bit_lrck;
                    locked    <= 1'b1;
                end
            end
        end
    end

    assign full    = (count == 2'd2);
    assign pop     = o_valid & o_ready;
    assign push_ok = push_req & (~full | pop);

    // Two-entry FIFO; a push into a full FIFO is accepted only when a pop frees the head
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_audio[i] <= '0;
                fifo_left[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                fifo_audio[wr_ptr] <= push_word;
                fifo_left[wr_ptr]  <= push_left;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign o_valid   = (count != 2'd0);
    assign o_audio   = fifo_audio[rd_ptr];
    assign o_is_left = fifo_left[rd_ptr];
    assign o_overrun = push_req & full & ~pop;

endmodule

// File: tb/tb_i2s_audio_receiver.sv
// Directed bench for i2s_audio_receiver: drives bit-level I2S frames with
// clk = 8x bck and compares the output stream with hand-computed words.
module tb_i2s_audio_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2s_bck;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_audio;
    logic        o_is_left;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;
    int ov_count = 0;
    int hold_err = 0;

    // Each received word is {is_left, audio}
    logic [16:0] rx_q [$];
    logic        pending_lsb;
    logic        held = 1'b0;
    logic [15:0] held_audio;
    logic        held_left;

    i2s_audio_receiver #(.audio_width(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .i2s_bck   (i2s_bck),
        .i2s_lrck  (i2s_lrck),
        .i2s_data  (i2s_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_audio   (o_audio),
        .o_is_left (o_is_left),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    // Record accepted words, overrun cycles and any change of a stalled head word
    always @(negedge clk) begin
        if (o_valid && o_ready) rx_q.push_back({o_is_left, o_audio});
        if (o_overrun) ov_count++;
        if (held && o_valid && (o_audio !== held_audio || o_is_left !== held_left)) hold_err++;
        held       = o_valid && !o_ready;
        held_audio = o_audio;
        held_left  = o_is_left;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One I2S bit: lrck/data change while bck is low, bck rises 4 clk later
    task automatic applyStimulus(input logic lr, input logic d);
        i2s_bck  = 1'b0;
        i2s_lrck = lr;
        i2s_data = d;
        repeat (4) @(posedge clk);
        #1 i2s_bck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One slot of n bits (left-aligned in bits); its last bit goes out with the next lrck
    task automatic sendSlot(input logic lr, input logic [31:0] bits, input int n);
        applyStimulus(lr, pending_lsb);
        for (int i = 0; i < n - 1; i++) applyStimulus(lr, bits[31-i]);
        pending_lsb = bits[32-n];
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        i2s_bck = 1'b0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        pending_lsb = 1'b0;
        rx_q.delete();
        ov_count = 0;
        hold_err = 0;
    endtask

    function automatic logic [31:0] rxWord(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        reset = 1'b1; i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0; o_ready = 1'b0;
        pending_lsb = 1'b0;

        // Reset values
        doReset();
        checkOutput("reset o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset o_audio", 32'(o_audio), 32'd0);
        checkOutput("reset o_is_left", 32'(o_is_left), 32'd0);
        checkOutput("reset o_overrun", 32'(o_overrun), 32'd0);

        // Lock-up with 32-bit slots: the first left slot is pre-lock and discarded
        o_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            sendSlot(1'b0, {16'h1234, 16'h0000}, 32);
            sendSlot(1'b1, {16'hABCD, 16'h0000}, 32);
        end
        repeat (10) @(posedge clk);
        #1;
        checkOutput("lock count", rx_q.size(), 32'd4);
        checkOutput("lock word0", rxWord(0), 32'h0_ABCD);
        checkOutput("lock word1", rxWord(1), 32'h1_1234);
        checkOutput("lock word2", rxWord(2), 32'h0_ABCD);
        checkOutput("lock word3", rxWord(3), 32'h1_1234);
        checkOutput("lock overrun", ov_count, 32'd0);

        // 24-bit slots truncate to the top 16 bits
        doReset();
        o_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            sendSlot(1'b0, {24'hFFEE11, 8'h00}, 24);
            sendSlot(1'b1, {24'h123456, 8'h00}, 24);
        end
        repeat (10) @(posedge clk);
        #1;
        checkOutput("trunc count", rx_q.size(), 32'd2);
        checkOutput("trunc right", rxWord(0), 32'h0_1234);
        checkOutput("trunc left", rxWord(1), 32'h1_FFEE);

        // 8-bit slots are zero-padded in the LSBs
        doReset();
        o_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            sendSlot(1'b0, {8'hA5, 24'h000000}, 8);
            sendSlot(1'b1, {8'h3C, 24'h000000}, 8);
        end
        repeat (10) @(posedge clk);
        #1;
        checkOutput("pad count", rx_q.size(), 32'd2);
        checkOutput("pad right", rxWord(0), 32'h0_3C00);
        checkOutput("pad left", rxWord(1), 32'h1_A500);

        // Backpressure: two words stored, third dropped with one overrun pulse
        doReset();
        o_ready = 1'b0;
        sendSlot(1'b0, {16'h1111, 16'h0000}, 32);
        sendSlot(1'b1, {16'hAAAA, 16'h0000}, 32);
        sendSlot(1'b0, {16'h2222, 16'h0000}, 32);
        sendSlot(1'b1, {16'hBBBB, 16'h0000}, 32);
        checkOutput("bp no early overrun", ov_count, 32'd0);
        sendSlot(1'b0, {16'h3333, 16'h0000}, 32);
        checkOutput("bp overrun pulses", ov_count, 32'd1);
        checkOutput("bp held valid", 32'(o_valid), 32'd1);
        checkOutput("bp held audio", 32'(o_audio), 32'h0000_AAAA);
        checkOutput("bp held is_left", 32'(o_is_left), 32'd0);
        checkOutput("bp hold stable", hold_err, 32'd0);
        o_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("bp drained count", rx_q.size(), 32'd2);
        checkOutput("bp word0", rxWord(0), 32'h0_AAAA);
        checkOutput("bp word1", rxWord(1), 32'h1_2222);
        checkOutput("bp drained valid", 32'(o_valid), 32'd0);

        // Push and pop on the same edge with one word queued
        doReset();
        o_ready = 1'b0;
        sendSlot(1'b0, {16'h1111, 16'h0000}, 32);
        sendSlot(1'b1, {16'hAAAA, 16'h0000}, 32);
        sendSlot(1'b0, {16'h2222, 16'h0000}, 32);
        applyStimulus(1'b1, pending_lsb);
        o_ready = 1'b1;
        @(posedge clk);
        #1 o_ready = 1'b0;
        checkOutput("pp valid", 32'(o_valid), 32'd1);
        checkOutput("pp head audio", 32'(o_audio), 32'h0000_2222);
        checkOutput("pp head is_left", 32'(o_is_left), 32'd1);
        checkOutput("pp overrun", ov_count, 32'd0);
        checkOutput("pp popped word", rxWord(0), 32'h0_AAAA);
        o_ready = 1'b1;
        @(posedge clk);
        #1 o_ready = 1'b0;
        checkOutput("pp occupancy one", 32'(o_valid), 32'd0);
        checkOutput("pp total words", rx_q.size(), 32'd2);

        // Latency and full-scale values with 16-bit slots
        doReset();
        o_ready = 1'b1;
        sendSlot(1'b0, {16'hAAAA, 16'h0000}, 16);
        sendSlot(1'b1, {16'h8000, 16'h0000}, 16);
        sendSlot(1'b0, {16'h7FFF, 16'h0000}, 16);
        applyStimulus(1'b1, pending_lsb);
        checkOutput("latency k+3 not valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency k+4 valid", 32'(o_valid), 32'd1);
        checkOutput("latency audio", 32'(o_audio), 32'h0000_7FFF);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("fullscale count", rx_q.size(), 32'd2);
        checkOutput("fullscale 8000", rxWord(0), 32'h0_8000);
        checkOutput("fullscale 7FFF", rxWord(1), 32'h1_7FFF);

        // Reset halfway through a left slot
        doReset();
        o_ready = 1'b0;
        sendSlot(1'b0, {16'h1111, 16'h0000}, 32);
        sendSlot(1'b1, {16'hAAAA, 16'h0000}, 32);
        applyStimulus(1'b0, pending_lsb);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("midrst pre valid", 32'(o_valid), 32'd1);
        i2s_bck = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("midrst valid cleared", 32'(o_valid), 32'd0);
        checkOutput("midrst audio cleared", 32'(o_audio), 32'd0);
        o_ready = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1);
        pending_lsb = 1'b1;
        sendSlot(1'b1, {16'h5555, 16'h0000}, 32);
        sendSlot(1'b0, {16'h1111, 16'h0000}, 32);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrst count", rx_q.size(), 32'd1);
        checkOutput("midrst first word", rxWord(0), 32'h0_5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] run did not complete");
    end

endmodule
